// File: rtl/stream_pkg.sv
// Shared definitions for the stream sequencer slice.
//   state_t     : sequencer FSM states (IDLE, RUN)
//   log2_ceil   : ceiling log2, used to size the raster counters
//   FRAME_CNT_W : width of the completed-frame counter
//   DEFAULT_*   : default VGA-style raster dimensions and the counter widths they need
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int FRAME_CNT_W = 16;

  // Smallest n with 2**n >= value. The loop stops at 30 so the shift never reaches the sign bit.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  localparam int DEFAULT_FRAME_HEIGHT = 525;
  localparam int DEFAULT_FRAME_WIDTH  = 800;
  localparam int DEFAULT_V_BITW       = log2_ceil(DEFAULT_FRAME_HEIGHT);
  localparam int DEFAULT_H_BITW       = log2_ceil(DEFAULT_FRAME_WIDTH);

endpackage

// File: rtl/stream_sequencer_raster_counter.sv
// Raster position counter: walks hcnt across FRAME_WIDTH columns and vcnt down
// FRAME_HEIGHT rows, one position per step.
//   clock, rst : clock and asynchronous active-high reset
//   clear      : return to (0,0) on the next edge, overrides step
//   step       : advance one raster position
//   vcnt, hcnt : current raster row / column
//   frame_end  : combinational, high when a step is taken at the last position of the frame
module raster_counter
  import stream_pkg::*;
#(
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int V_BITW       = log2_ceil(FRAME_HEIGHT),
  parameter int H_BITW       = log2_ceil(FRAME_WIDTH)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [V_BITW-1:0] vcnt,
  output logic [H_BITW-1:0] hcnt,
  output logic              frame_end
);

  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(FRAME_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(FRAME_WIDTH - 1);

  logic line_end;

  assign line_end  = step && (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (clear || frame_end) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (line_end) begin
      vcnt <= vcnt + V_BITW'(1);
      hcnt <= '0;
    end else if (step) begin
      hcnt <= hcnt + H_BITW'(1);
    end
  end

endmodule

// File: rtl/stream_sequencer.sv
// Raster sequencer for the patch-extraction datapath. Consumes the active-area
// pixel stream, walks the full frame raster (blanking included), inserts zero
// pixels during blanking and issues one dp_enable per raster step.
//   clock, rst            : clock and asynchronous active-high reset
//   start, continuous     : begin a frame from IDLE; chain frames when high at frame end
//   abort                 : drop the current frame and return to IDLE
//   in_valid/in_pixel     : upstream stream, consumed when in_valid && in_ready
//   in_ready              : upstream ready (combinational)
//   out_ready             : downstream can accept a datapath step
//   dp_enable             : registered datapath advance strobe
//   dp_pixel/vcnt/hcnt    : registered pixel and its raster position
//   busy                  : sequencer is in RUN
//   frame_done            : one-cycle pulse with the final dp_enable of a frame
//   frame_cnt             : completed frames, wraps at 16 bits
module stream_sequencer
  import stream_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int V_BITW       = log2_ceil(FRAME_HEIGHT),
  parameter int H_BITW       = log2_ceil(FRAME_WIDTH)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [BIT_WIDTH-1:0]   in_pixel,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   dp_enable,
  output logic [BIT_WIDTH-1:0]   dp_pixel,
  output logic [V_BITW-1:0]      dp_vcnt,
  output logic [H_BITW-1:0]      dp_hcnt,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [V_BITW-1:0] V_ACTIVE = V_BITW'(IMAGE_HEIGHT);
  localparam logic [H_BITW-1:0] H_ACTIVE = H_BITW'(IMAGE_WIDTH);

  state_t                 state;
  state_t                 state_next;
  logic [V_BITW-1:0]      vcnt;
  logic [H_BITW-1:0]      hcnt;
  logic                   frame_end;
  logic                   active;
  logic                   step;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Abort also clears the raster, so a restarted frame always begins at (0,0).
  raster_counter #(
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .FRAME_WIDTH  (FRAME_WIDTH),
    .V_BITW       (V_BITW),
    .H_BITW       (H_BITW)
  ) u_raster (
    .clock     (clock),
    .rst       (rst),
    .clear     (abort),
    .step      (step),
    .vcnt      (vcnt),
    .hcnt      (hcnt),
    .frame_end (frame_end)
  );

  assign active = (vcnt < V_ACTIVE) && (hcnt < H_ACTIVE);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort wins over both start (in IDLE) and the frame-end transition (in RUN).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (frame_end && !continuous) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Blanking positions need no input pixel, so they only wait on out_ready.
  always_comb begin
    busy     = (state == RUN);
    in_ready = (state == RUN) && !abort && active && out_ready;
    step     = (state == RUN) && !abort && out_ready && (!active || in_valid);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dp_enable   <= 1'b0;
      dp_pixel    <= '0;
      dp_vcnt     <= '0;
      dp_hcnt     <= '0;
      frame_done  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      dp_enable  <= step;
      frame_done <= frame_end;
      if (step) begin
        dp_pixel <= active ? in_pixel : '0;
        dp_vcnt  <= vcnt;
        dp_hcnt  <= hcnt;
      end
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stream_sequencer.sv
// Self-checking bench for stream_sequencer on a 4x3 active / 6x4 total raster.
module tb_stream_sequencer;

  localparam int BW = 8;
  localparam int IH = 3;
  localparam int IW = 4;
  localparam int FH = 4;
  localparam int FW = 6;
  localparam int VW = 2;
  localparam int HW = 3;
  localparam int FRAME_STEPS = FH * FW;

  logic          clock = 1'b0;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          abort;
  logic          in_valid;
  logic [BW-1:0] in_pixel;
  logic          in_ready;
  logic          out_ready;
  logic          dp_enable;
  logic [BW-1:0] dp_pixel;
  logic [VW-1:0] dp_vcnt;
  logic [HW-1:0] dp_hcnt;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  stream_sequencer #(
    .BIT_WIDTH    (BW),
    .IMAGE_HEIGHT (IH),
    .IMAGE_WIDTH  (IW),
    .FRAME_HEIGHT (FH),
    .FRAME_WIDTH  (FW)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .dp_enable  (dp_enable),
    .dp_pixel   (dp_pixel),
    .dp_vcnt    (dp_vcnt),
    .dp_hcnt    (dp_hcnt),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          st;
    bit          co;
    bit          ab;
    bit          iv;
    logic [7:0]  px;
    bit          ordy;
    bit          eReady;
    bit          eEn;
    logic [7:0]  ePix;
    int          eV;
    int          eH;
    bit          eBusy;
    bit          eDone;
  } vector_t;

  vector_t vecs[9];

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: linear raster index plus frame bookkeeping.
  bit          mRun;
  int          mPos;
  logic [15:0] mFrameCnt;
  bit          mEn;
  logic [7:0]  mPix;
  int          mV;
  int          mH;
  bit          mDone;
  bit          mConsumed;

  logic [7:0]  nextPix;
  logic [7:0]  seen[$];
  int          enCnt;
  int          consCnt;

  function automatic bit modelActive(input int pos);
    return ((pos / FW) < IH) && ((pos % FW) < IW);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: timeout at %0t", name, $time);
  endtask

  task automatic applyStimulus(input bit st, input bit co, input bit ab, input bit iv,
                               input logic [7:0] px, input bit ordy);
    start      = st;
    continuous = co;
    abort      = ab;
    in_valid   = iv;
    in_pixel   = px;
    out_ready  = ordy;
  endtask

  task automatic drive(input bit st, input bit co, input bit ab, input bit iv, input bit ordy);
    applyStimulus(st, co, ab, iv, nextPix, ordy);
  endtask

  task automatic modelReset();
    mRun      = 1'b0;
    mPos      = 0;
    mFrameCnt = 16'h0000;
    mEn       = 1'b0;
    mPix      = 8'h00;
    mV        = 0;
    mH        = 0;
    mDone     = 1'b0;
    mConsumed = 1'b0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check registered outputs after it.
  task automatic cycle();
    bit act;
    bit stp;
    bit expReady;
    bit wasRun;
    act      = modelActive(mPos);
    wasRun   = mRun;
    expReady = mRun && !abort && act && out_ready;
    stp      = mRun && !abort && out_ready && (!act || in_valid);
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    if (in_valid && in_ready) consCnt++;
    @(posedge clock);
    mConsumed = stp && act;
    if (stp) begin
      mEn = 1'b1;
      mPix = act ? in_pixel : 8'h00;
      mV = mPos / FW;
      mH = mPos % FW;
      if (mPos == FRAME_STEPS - 1) begin
        mDone = 1'b1;
        mFrameCnt = mFrameCnt + 16'h0001;
        mPos = 0;
        mRun = continuous;
      end else begin
        mDone = 1'b0;
        mPos = mPos + 1;
      end
    end else begin
      mEn = 1'b0;
      mDone = 1'b0;
    end
    if (abort) begin
      mRun = 1'b0;
      mPos = 0;
    end else if (!wasRun && start) begin
      mRun = 1'b1;
    end
    #1;
    checkOutput("dp_enable", 32'(dp_enable), 32'(mEn));
    checkOutput("dp_pixel", 32'(dp_pixel), 32'(mPix));
    checkOutput("dp_vcnt", 32'(dp_vcnt), mV);
    checkOutput("dp_hcnt", 32'(dp_hcnt), mH);
    checkOutput("busy", 32'(busy), 32'(mRun));
    checkOutput("frame_done", 32'(frame_done), 32'(mDone));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(mFrameCnt));
    if (dp_enable) enCnt++;
    if (dp_enable && (int'(dp_vcnt) < IH) && (int'(dp_hcnt) < IW)) seen.push_back(dp_pixel);
    if (mConsumed) nextPix = nextPix + 8'h01;
    @(negedge clock);
  endtask

  task automatic resetDut();
    applyStimulus(0, 0, 0, 0, 8'h00, 0);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    modelReset();
    nextPix = 8'h01;
    seen.delete();
    enCnt = 0;
    consCnt = 0;
  endtask

  task automatic runToPos(input int target);
    int n;
    n = 0;
    while (!(mRun && mPos == target) && n < 100) begin
      drive(0, 0, 0, 1, 1);
      cycle();
      n++;
    end
    if (n >= 100) reportTimeout("run_to_pos");
  endtask

  task automatic runToIdle(input bit iv, input int limit);
    int n;
    n = 0;
    while (mRun && n < limit) begin
      drive(0, 0, 0, iv, 1);
      cycle();
      n++;
    end
    if (n >= limit) reportTimeout("run_to_idle");
  endtask

  task automatic checkSeenSequence(input string name, input int count);
    checkOutput({name, " count"}, seen.size(), count);
    for (int i = 0; i < seen.size() && i < count; i++) begin
      checkOutput(name, 32'(seen[i]), i + 1);
    end
  endtask

  initial begin
    int gaps;
    int doneAt;
    logic [15:0] cntBefore;

    vecs[0] = '{1, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    vecs[1] = '{0, 0, 0, 1, 8'h11, 1, 1, 1, 8'h11, 0, 0, 1, 0};
    vecs[2] = '{0, 0, 0, 1, 8'h22, 0, 0, 0, 8'h11, 0, 0, 1, 0};
    vecs[3] = '{0, 0, 0, 0, 8'h33, 1, 1, 0, 8'h11, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 0, 1, 8'h44, 1, 1, 1, 8'h44, 0, 1, 1, 0};
    vecs[5] = '{0, 0, 1, 1, 8'h55, 1, 0, 0, 8'h44, 0, 1, 0, 0};
    vecs[6] = '{1, 0, 1, 0, 8'h00, 1, 0, 0, 8'h44, 0, 1, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 8'h00, 1, 0, 0, 8'h44, 0, 1, 1, 0};
    vecs[8] = '{0, 0, 0, 1, 8'h66, 1, 1, 1, 8'h66, 0, 0, 1, 0};

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'h00, 0);
    @(negedge clock);
    @(negedge clock);
    $display("[TB] reset state");
    checkOutput("rst dp_enable", 32'(dp_enable), 0);
    checkOutput("rst dp_pixel", 32'(dp_pixel), 0);
    checkOutput("rst dp_vcnt", 32'(dp_vcnt), 0);
    checkOutput("rst dp_hcnt", 32'(dp_hcnt), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst frame_done", 32'(frame_done), 0);
    checkOutput("rst frame_cnt", 32'(frame_cnt), 0);
    checkOutput("rst in_ready", 32'(in_ready), 0);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].st, vecs[i].co, vecs[i].ab, vecs[i].iv, vecs[i].px, vecs[i].ordy);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].eReady));
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d dp_enable", i), 32'(dp_enable), 32'(vecs[i].eEn));
      checkOutput($sformatf("vec%0d dp_pixel", i), 32'(dp_pixel), 32'(vecs[i].ePix));
      checkOutput($sformatf("vec%0d dp_vcnt", i), 32'(dp_vcnt), vecs[i].eV);
      checkOutput($sformatf("vec%0d dp_hcnt", i), 32'(dp_hcnt), vecs[i].eH);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(vecs[i].eDone));
      @(negedge clock);
    end

    $display("[TB] full frame");
    resetDut();
    doneAt = 0;
    drive(1, 0, 0, 1, 1);
    cycle();
    for (int n = 0; n < 40 && mRun; n++) begin
      drive(0, 0, 0, 1, 1);
      cycle();
      if (frame_done) doneAt = enCnt;
    end
    checkOutput("frame enables", enCnt, FRAME_STEPS);
    checkOutput("frame consumed", consCnt, IH * IW);
    checkOutput("frame_done step", doneAt, FRAME_STEPS);
    checkOutput("frame busy falls", 32'(busy), 0);
    checkSeenSequence("frame pixels", IH * IW);

    $display("[TB] input starvation");
    resetDut();
    drive(1, 0, 0, 1, 1);
    cycle();
    runToPos(1 * FW + 2);
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 0, 0, 1);
      cycle();
      checkOutput("starve dp_enable", 32'(dp_enable), 0);
      checkOutput("starve dp_vcnt", 32'(dp_vcnt), 1);
      checkOutput("starve dp_hcnt", 32'(dp_hcnt), 1);
    end
    runToIdle(1, 40);
    checkSeenSequence("starve pixels", IH * IW);

    $display("[TB] backpressure in blanking");
    resetDut();
    drive(1, 0, 0, 1, 1);
    cycle();
    runToPos(2 * FW + 5);
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 0, 1, 0);
      cycle();
      checkOutput("bp dp_enable", 32'(dp_enable), 0);
    end
    enCnt = 0;
    runToIdle(0, 20);
    checkOutput("blank steps", enCnt, FRAME_STEPS - (2 * FW + 5));
    checkOutput("blank frame_cnt", 32'(frame_cnt), 1);

    $display("[TB] abort");
    resetDut();
    drive(1, 0, 0, 1, 1);
    cycle();
    runToPos(2 * FW + 1);
    cntBefore = frame_cnt;
    consCnt = 0;
    drive(0, 0, 1, 1, 1);
    cycle();
    checkOutput("abort consumed", consCnt, 0);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort frame_cnt", 32'(frame_cnt), 32'(cntBefore));
    drive(1, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 1, 1);
    cycle();
    checkOutput("restart dp_enable", 32'(dp_enable), 1);
    checkOutput("restart dp_vcnt", 32'(dp_vcnt), 0);
    checkOutput("restart dp_hcnt", 32'(dp_hcnt), 0);
    runToIdle(1, 40);

    $display("[TB] continuous frames");
    resetDut();
    drive(1, 1, 0, 1, 1);
    cycle();
    gaps = 0;
    for (int n = 0; n < 100 && mRun; n++) begin
      drive(0, (mFrameCnt < 16'd2), 0, 1, 1);
      cycle();
      if (!dp_enable) gaps++;
    end
    checkOutput("cont frame_cnt", 32'(frame_cnt), 3);
    checkOutput("cont gaps", gaps, 0);
    checkOutput("cont enables", enCnt, 3 * FRAME_STEPS);
    checkOutput("cont busy", 32'(busy), 0);

    $display("[TB] async reset mid-frame");
    drive(1, 0, 0, 1, 1);
    cycle();
    runToPos(10);
    @(posedge clock);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst dp_enable", 32'(dp_enable), 0);
    checkOutput("arst dp_pixel", 32'(dp_pixel), 0);
    checkOutput("arst dp_vcnt", 32'(dp_vcnt), 0);
    checkOutput("arst dp_hcnt", 32'(dp_hcnt), 0);
    checkOutput("arst busy", 32'(busy), 0);
    checkOutput("arst frame_done", 32'(frame_done), 0);
    checkOutput("arst frame_cnt", 32'(frame_cnt), 0);
    checkOutput("arst in_ready", 32'(in_ready), 0);
    @(negedge clock);
    rst = 1'b0;
    modelReset();
    nextPix = 8'h01;
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_cnt_q;
    mFrameCnt = 16'hFFFF;
    drive(1, 0, 0, 1, 1);
    cycle();
    runToIdle(1, 40);
    checkOutput("wrap frame_cnt", 32'(frame_cnt), 0);

    $display("[TB] random stimulus");
    resetDut();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
                    8'($urandom), ($urandom_range(0, 9) < 8));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
